// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared definitions for the register-address decoder and register file.
//   Provides the default address width, the one-hot width derivation and a
//   one-hot conversion helper.
//   onehot_of() works at the maximum supported width (MAX_ADDR_W); callers
//   zero-extend the address and truncate the result to their own NUM_REGS.
package decoder_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 5;
   localparam int unsigned MAX_ADDR_W     = 8;
   localparam int unsigned MAX_REGS       = 1 << MAX_ADDR_W;

   function automatic int unsigned num_regs(input int unsigned addr_w);
      return 1 << addr_w;
   endfunction

   function automatic logic [MAX_REGS-1:0] onehot_of(input logic [MAX_ADDR_W-1:0] addr);
      logic [MAX_REGS-1:0] v;
      v = '0;
      v[addr] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder_scoreboard_popcount.sv
// decoder_scoreboard_popcount
//   Combinational population count of a WIDTH-bit vector.
//   Ports:
//     bits   in   WIDTH                 vector to count
//     count  out  $clog2(WIDTH+1)       number of set bits
module decoder_scoreboard_popcount #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]           bits,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/decoder_scoreboard.sv
// decoder_scoreboard
//   Decodes an ADDR_W-bit destination register address into a registered
//   one-hot write enable behind a valid/ready handshake, and keeps a busy-bit
//   scoreboard of pending writes that stalls write-after-write hazards.
//   Optional build macro: DECODER_SCOREBOARD_ZERO_REG_EN -- register 0 is
//   hardwired zero (decodes to an all-zero one-hot, is never marked busy).
//   Ports:
//     clock        in   1           rising-edge clock
//     reset        in   1           synchronous reset, active low
//     in_valid     in   1           decode request present
//     in_ready     out  1           request accepted this cycle
//     in_addr      in   ADDR_W      destination register address
//     in_set_busy  in   1           mark in_addr pending on accept
//     out_valid    out  1           out_onehot holds valid data
//     out_ready    in   1           downstream consumes the output
//     out_onehot   out  NUM_REGS    registered one-hot decode
//     wb_valid     in   1           writeback completes, clears busy
//     wb_addr      in   ADDR_W      writeback register address
//     rs_a_addr    in   ADDR_W      hazard query A
//     rs_b_addr    in   ADDR_W      hazard query B
//     rs_a_busy    out  1           busy[rs_a_addr]
//     rs_b_busy    out  1           busy[rs_b_addr]
//     busy         out  NUM_REGS    scoreboard vector
//     busy_count   out  ADDR_W+1    registered population count of busy
module decoder_scoreboard
   import decoder_pkg::*;
#(
   parameter  int unsigned ADDR_W   = ADDR_W_DEFAULT,
   localparam int unsigned NUM_REGS = num_regs(ADDR_W)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic                in_set_busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_REGS-1:0] out_onehot,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [ADDR_W-1:0]   rs_a_addr,
   input  logic [ADDR_W-1:0]   rs_b_addr,
   output logic                rs_a_busy,
   output logic                rs_b_busy,
   output logic [NUM_REGS-1:0] busy,
   output logic [ADDR_W:0]     busy_count
);

   logic                waw_stall;
   logic                accept;
   logic                addr_is_zero_reg;
   logic [NUM_REGS-1:0] decoded;
   logic [NUM_REGS-1:0] busy_next;
   logic [ADDR_W:0]     count_next;

`ifdef DECODER_SCOREBOARD_ZERO_REG_EN
   assign addr_is_zero_reg = (in_addr == '0);
`else
   assign addr_is_zero_reg = 1'b0;
`endif

   // A same-cycle writeback to the requested register releases the stall.
   assign waw_stall = in_set_busy && busy[in_addr] && !addr_is_zero_reg &&
                      !(wb_valid && (wb_addr == in_addr));
   assign in_ready  = (!out_valid || out_ready) && !waw_stall;
   assign accept    = in_valid && in_ready;

   assign decoded = addr_is_zero_reg ? '0
                                     : NUM_REGS'(onehot_of(MAX_ADDR_W'(in_addr)));

   // Clear first, then set, so a same-cycle set on the same index wins.
   always_comb begin
      busy_next = busy;
      if (wb_valid) begin
         busy_next[wb_addr] = 1'b0;
      end
      if (accept && in_set_busy && !addr_is_zero_reg) begin
         busy_next[in_addr] = 1'b1;
      end
   end

   decoder_scoreboard_popcount #(
      .WIDTH (NUM_REGS)
   ) u_popcount (
      .bits  (busy_next),
      .count (count_next)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_onehot <= '0;
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_next;
         busy_count <= count_next;
         if (accept) begin
            out_onehot <= decoded;
            out_valid  <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

   // Queries see the registered scoreboard only; no writeback bypass.
   assign rs_a_busy = busy[rs_a_addr];
   assign rs_b_busy = busy[rs_b_addr];

endmodule

// File: tb/tb_decoder_scoreboard.sv
// tb_decoder_scoreboard
//   Directed-vector bench for decoder_scoreboard with ADDR_W=5.
module tb_decoder_scoreboard;

   localparam int unsigned AW = 5;
   localparam int unsigned NR = 32;

   logic          clock;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic          in_set_busy;
   logic          out_valid;
   logic          out_ready;
   logic [NR-1:0] out_onehot;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [AW-1:0] rs_a_addr;
   logic [AW-1:0] rs_b_addr;
   logic          rs_a_busy;
   logic          rs_b_busy;
   logic [NR-1:0] busy;
   logic [AW:0]   busy_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   decoder_scoreboard #(
      .ADDR_W (AW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_addr     (in_addr),
      .in_set_busy (in_set_busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_onehot  (out_onehot),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .rs_a_addr   (rs_a_addr),
      .rs_b_addr   (rs_b_addr),
      .rs_a_busy   (rs_a_busy),
      .rs_b_busy   (rs_b_busy),
      .busy        (busy),
      .busy_count  (busy_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [63:0] exp_oh;

      reset       = 1'b0;
      in_valid    = 1'b0;
      in_addr     = '0;
      in_set_busy = 1'b0;
      out_ready   = 1'b0;
      wb_valid    = 1'b0;
      wb_addr     = '0;
      rs_a_addr   = '0;
      rs_b_addr   = '0;

      // Reset held for two cycles
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_onehot", 64'(out_onehot), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_busy_count", 64'(busy_count), 64'd0);
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_addr   = 5'd7;
      out_ready = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Decode sweep, back-to-back
      for (int unsigned a = 0; a < NR; a++) begin
         in_addr = AW'(a);
         #1;
         check("sweep_in_ready", 64'(in_ready), 64'd1);
         tick();
         exp_oh = 64'd1 << a;
         check("sweep_valid", 64'(out_valid), 64'd1);
         check("sweep_onehot", 64'(out_onehot), exp_oh);
      end
      in_valid = 1'b0;
      tick();
      check("sweep_drain", 64'(out_valid), 64'd0);

      // Backpressure
      in_valid  = 1'b1;
      in_addr   = 5'd5;
      out_ready = 1'b0;
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_onehot", 64'(out_onehot), 64'h20);
      in_addr = 5'd9;
      for (int unsigned c = 0; c < 3; c++) begin
         #1;
         check("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_onehot", 64'(out_onehot), 64'h20);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      tick();
      check("bp_next_onehot", 64'(out_onehot), 64'h200);
      check("bp_next_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      tick();
      check("bp_drain", 64'(out_valid), 64'd0);

      // WAW stall and writeback release
      in_valid    = 1'b1;
      in_addr     = 5'd3;
      in_set_busy = 1'b1;
      tick();
      check("waw_busy_set", 64'(busy), 64'h8);
      check("waw_count1", 64'(busy_count), 64'd1);
      #1;
      check("waw_stall", 64'(in_ready), 64'd0);
      tick();
      check("waw_no_accept", 64'(out_valid), 64'd0);
      check("waw_busy_held", 64'(busy), 64'h8);
      wb_valid = 1'b1;
      wb_addr  = 5'd3;
      #1;
      check("waw_wb_lift", 64'(in_ready), 64'd1);
      tick();
      check("waw_set_wins", 64'(busy), 64'h8);
      check("waw_set_wins_cnt", 64'(busy_count), 64'd1);
      check("waw_accept_onehot", 64'(out_onehot), 64'h8);
      in_valid = 1'b0;
      tick();
      check("wb_clear", 64'(busy), 64'd0);
      check("wb_clear_cnt", 64'(busy_count), 64'd0);
      wb_addr = 5'd12;
      tick();
      check("wb_nonbusy_noop", 64'(busy), 64'd0);
      check("wb_nonbusy_cnt", 64'(busy_count), 64'd0);
      wb_valid = 1'b0;

      // Hazard queries and count
      in_valid = 1'b1;
      in_addr  = 5'd4;
      tick();
      in_addr = 5'd10;
      tick();
      in_addr = 5'd31;
      tick();
      in_valid  = 1'b0;
      rs_a_addr = 5'd10;
      rs_b_addr = 5'd11;
      #1;
      check("hz_busy", 64'(busy), 64'h8000_0410);
      check("hz_count3", 64'(busy_count), 64'd3);
      check("hz_rs_a", 64'(rs_a_busy), 64'd1);
      check("hz_rs_b", 64'(rs_b_busy), 64'd0);
      in_valid = 1'b1;
      in_addr  = 5'd31;
      #1;
      check("hz_waw31", 64'(in_ready), 64'd0);
      in_set_busy = 1'b0;
      #1;
      check("hz_no_setbusy_ready", 64'(in_ready), 64'd1);
      in_valid    = 1'b0;
      in_set_busy = 1'b1;
      wb_valid    = 1'b1;
      wb_addr     = 5'd10;
      #1;
      check("hz_no_bypass", 64'(rs_a_busy), 64'd1);
      tick();
      wb_valid = 1'b0;
      check("hz_count2", 64'(busy_count), 64'd2);
      check("hz_rs_a_clear", 64'(rs_a_busy), 64'd0);
      check("hz_busy2", 64'(busy), 64'h8000_0010);

      // Register 0
      in_valid = 1'b1;
      in_addr  = 5'd0;
      rs_b_addr = 5'd0;
      tick();
      in_valid = 1'b0;
      check("z_valid", 64'(out_valid), 64'd1);
`ifdef DECODER_SCOREBOARD_ZERO_REG_EN
      check("z_onehot", 64'(out_onehot), 64'd0);
      check("z_busy", 64'(busy), 64'h8000_0010);
      check("z_count", 64'(busy_count), 64'd2);
      check("z_rs_b", 64'(rs_b_busy), 64'd0);
      in_valid = 1'b1;
      #1;
      check("z_no_stall", 64'(in_ready), 64'd1);
`else
      check("z_onehot", 64'(out_onehot), 64'd1);
      check("z_busy", 64'(busy), 64'h8000_0011);
      check("z_count", 64'(busy_count), 64'd3);
      check("z_rs_b", 64'(rs_b_busy), 64'd1);
      in_valid = 1'b1;
      #1;
      check("z_stall", 64'(in_ready), 64'd0);
`endif
      in_valid = 1'b0;

      // Reset discards an in-flight output and ignores a writeback
      in_valid  = 1'b1;
      in_addr   = 5'd20;
      in_set_busy = 1'b0;
      out_ready = 1'b0;
      tick();
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      reset    = 1'b0;
      wb_valid = 1'b1;
      wb_addr  = 5'd4;
      tick();
      check("rst2_valid", 64'(out_valid), 64'd0);
      check("rst2_onehot", 64'(out_onehot), 64'd0);
      check("rst2_busy", 64'(busy), 64'd0);
      check("rst2_count", 64'(busy_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_scoreboard.md
Name: decoder_scoreboard

Overview:
- Parametrised successor to the processor's fixed 5-to-32 one-hot decoder.
- Decodes an ADDR_W-bit register address into a registered 2^ADDR_W one-hot write-enable, with a valid/ready handshake.
- Keeps a busy-bit scoreboard of pending register writes and stalls write-after-write hazards.
- Sits between decode/issue and the register file write port; read-hazard queries feed the stall logic.

Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 2**ADDR_W, one-hot width. Derived; never overridden.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- in_valid  in  1  decode request present
- in_ready  out  1  request accepted this cycle
- in_addr  in  ADDR_W  destination register address
- in_set_busy  in  1  mark in_addr pending when the request is accepted
- out_valid  out  1  one-hot output holds valid data
- out_ready  in  1  downstream consumes the output
- out_onehot  out  NUM_REGS  registered one-hot decode
- wb_valid  in  1  writeback completes, clears busy
- wb_addr  in  ADDR_W  writeback register address
- rs_a_addr  in  ADDR_W  hazard query A
- rs_b_addr  in  ADDR_W  hazard query B
- rs_a_busy  out  1  busy[rs_a_addr], combinational
- rs_b_busy  out  1  busy[rs_b_addr], combinational
- busy  out  NUM_REGS  scoreboard vector
- busy_count  out  ADDR_W+1  population count of busy

Behaviour:
- Reset: synchronous, active-low, on the clock edge while reset==0.
  - out_valid=0, out_onehot=0, busy=0, busy_count=0.
  - An in-flight output is discarded. A writeback in the reset cycle is ignored.
- Handshake: accept = in_valid && in_ready. Output moves when out_valid && out_ready.
- in_ready = (!out_valid || out_ready) && !waw_stall.
  - waw_stall = in_set_busy && busy[in_addr] && !(wb_valid && wb_addr==in_addr).
  - A writeback to the same register in the same cycle lifts the stall.
- Latency: 1 cycle.
  - On accept: out_onehot <= 1<<in_addr, out_valid <= 1.
  - On output move with no accept: out_valid <= 0. out_onehot is held, but downstream qualifies it with out_valid.
  - Accept plus move in the same cycle gives back-to-back throughput of 1 per cycle.
- Output stability: out_onehot and out_valid hold steady while out_valid && !out_ready.
- Scoreboard update each cycle:
  - Clear: if wb_valid, busy[wb_addr] is cleared.
  - Set: if accept && in_set_busy, busy[in_addr] is set.
  - Set wins over clear for the same index in the same cycle.
- Writeback to a non-busy register is a no-op, with no error.
- busy_count is registered, consistent with busy after each edge, and saturates naturally: max NUM_REGS fits in ADDR_W+1 bits.
- Hazard queries read the current registered busy. There is no writeback bypass.

Optional Feature:
- Macro: DECODER_SCOREBOARD_ZERO_REG_EN.
- When defined, register 0 is hardwired zero:
  - in_addr==0 decodes to out_onehot=0 but still produces out_valid=1.
  - busy[0] is never set, so rs_*_busy for address 0 is always 0.
  - waw_stall never fires for address 0.
- When undefined, address 0 behaves like any other register.

Decomposition:
- Shared package decoder_pkg holds:
  - the ADDR_W default;
  - the NUM_REGS derivation function;
  - a onehot_of(addr) function reused by the register file.
- One natural sub-module: popcount (parametrised width), used for busy_count.
- Decode, handshake and scoreboard stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release.
  - Response: out_valid=0, busy=0, busy_count=0. in_ready=1 with in_valid=1 and in_addr=7.
- Decode sweep: addresses 0..31 with out_ready=1, no set_busy.
  - Response: out_onehot=1<<addr one cycle after accept, 32 back-to-back outputs.
- Backpressure: accept addr=5, hold out_ready=0 for 3 cycles, then present addr=9.
  - Response: in_ready=0, out_onehot stays 0x20. When out_ready=1, 0x200 follows the next cycle.
- WAW stall:
  - issue addr=3 with set_busy, then addr=3 with set_busy again → in_ready=0.
  - wb_valid=1, wb_addr=3 in the same cycle → accept; busy[3] remains 1 because set wins.
- Hazard and count:
  - set_busy on 4, 10, 31 → busy_count=3, rs_a_addr=10 gives rs_a_busy=1.
  - wb 10 → busy_count=2 next cycle, rs_a_busy=0.
- Zero register, with macro defined: issue addr=0 with set_busy.
  - Response: out_valid=1, out_onehot=0, busy[0]=0, busy_count unchanged.
